alu_trace_writer: RTL and testbench
===================================

// Module: alu_trace_writer
// PURPOSE
//  Capture side of the ALU test-vector format. Watches the alu32 operands and results,
//  packs each sample into one 101-bit record: {Overflow, Zero, F[2:0], A, B, Y}.
//  Buffers the records and streams them out as 32-bit words over a valid/ready link.
//  Used to record golden vectors from a reference run in the same format the checker bench reads.
// PARAMETERS
//  DEPTH    16  record FIFO entries; power of two, >= 2
//  CNT_W    32  width of rec_count / drop_count
// PORTS
//  clk          in   1      single clock, all logic on rising edge
//  rst_n        in   1      synchronous, active-low reset
//  cap_valid    in   1      sample strobe, one record per cycle when high
//  cap_f        in   3      ALU function code F
//  cap_a        in   32     operand A
//  cap_b        in   32     operand B
//  cap_y        in   32     ALU result
//  cap_zero     in   1      ALU Zero flag
//  cap_ovf      in   1      ALU Overflow flag
//  out_valid    out  1      out_data valid
//  out_ready    in   1      sink accepts the word
//  out_data     out  32     serialized record word
//  out_last     out  1      high on the 4th (final) word of a record
//  full         out  1      FIFO holds DEPTH records
//  empty        out  1      FIFO holds 0 records
//  rec_count    out  CNT_W  accepted captures; wraps mod 2^CNT_W
//  drop_count   out  CNT_W  captures dropped while full; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at an edge)
//   - Zero at the next edge: out_valid, out_last, out_data, rec_count, drop_count.
//   - FIFO pointers cleared: empty=1, full=0. FSM goes to IDLE.
//   - Reset mid-record discards the partial record and all buffered records.
//  Capture
//   - cap_valid && !full: push {cap_ovf, cap_zero, cap_f, cap_a, cap_b, cap_y}; rec_count++.
//   - cap_valid && full: drop the sample; drop_count++ (saturating).
//   - full is the registered state. A pop in the same cycle does not rescue the capture; it is dropped.
//  Record layout (bit 100 down to 0)
//   - [100] ovf | [99] zero | [98:96] F | [95:64] A | [63:32] B | [31:0] Y
//  Serializer FSM states: IDLE, W0, W1, W2, W3
//   - IDLE: if !empty, pop the head into the 101-bit shift register, go to W0; else stay.
//   - W0: out_data = {27'b0, ovf, zero, F}.
//   - W1: out_data = A.  W2: out_data = B.
//   - W3: out_data = Y, out_last = 1.
//   - out_valid = 1 in W0..W3. Advance only on out_valid && out_ready.
//   - out_data and out_last hold stable while out_valid && !out_ready.
//   - W3 handshake with !empty: pop the next record and go straight to W0 (no bubble).
//   - W3 handshake with empty: go to IDLE.
//  Latency and capacity
//   - Capture at edge t into an idle, empty block gives out_valid=1 after edge t+2.
//   - Throughput is 1 record per 4 accepted words.
//   - Capacity = DEPTH in the FIFO + 1 record in the serializer.
//  Simultaneous push and pop on a non-full FIFO: both happen; occupancy unchanged.
// STRUCTURE
//  - Package alu_trace_pkg: REC_W=101, WORD_W=32, field offset localparams,
//    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} trace_state_t, typedef logic [REC_W-1:0] trace_rec_t.
//  - Sub-module sync_fifo #(WIDTH=REC_W, DEPTH): single clock, sync active-low reset, push/pop/full/empty.
//  - Top holds the capture logic, the counters and the serializer FSM.
// TESTING
//  1 Add: F=2, A=00000005, B=00000003, Y=00000008, zero=0, ovf=0, out_ready=1
//    -> words 00000002, 00000005, 00000003, 00000008; out_last on the 4th; out_valid first at t+2.
//  2 Overflow: F=2, A=7FFFFFFF, B=00000001, Y=80000000, ovf=1 -> word0=00000012, last word=80000000.
//    Zero: F=6, A=B=00000005, Y=0, zero=1 -> word0=0000000E.
//  3 Backpressure: one record, out_ready=0 for 10 cycles in W1
//    -> out_data=A held for 10 cycles; release gives remaining words in order.
//  4 Overflow of the buffer: DEPTH=16, out_ready=0, 18 back-to-back captures
//    -> rec_count=17, drop_count=1, full=1; then drain 68 words in order, empty=1.
//  5 Back-to-back: 3 records, out_ready=1 -> 12 consecutive valid words, no IDLE bubble between records.
//  6 Reset mid-record: rst_n=0 for 1 cycle while in W2 with 5 records queued
//    -> next edge: out_valid=0, empty=1, rec_count=0, drop_count=0; a new capture streams normally.

Source files
------------

// File: rtl/alu_trace_pkg.sv
// Shared types and record layout for the ALU trace capture path.
// A record is {ovf, zero, F, A, B, Y}, 101 bits, streamed as four 32-bit words.
package alu_trace_pkg;

    localparam int unsigned REC_W    = 101;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned F_W      = 3;
    localparam int unsigned Y_LSB    = 0;
    localparam int unsigned B_LSB    = 32;
    localparam int unsigned A_LSB    = 64;
    localparam int unsigned F_LSB    = 96;
    localparam int unsigned ZERO_BIT = 99;
    localparam int unsigned OVF_BIT  = 100;

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} trace_state_t;
    typedef logic [REC_W-1:0] trace_rec_t;

    function automatic trace_rec_t pack_rec(
        input logic              ovf,
        input logic              zero,
        input logic [F_W-1:0]    f,
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input logic [WORD_W-1:0] y
    );
        return {ovf, zero, f, a, b, y};
    endfunction

endpackage

// File: rtl/alu_trace_writer_sync_fifo.sv
// Single-clock FIFO with extra-bit wrap pointers; head entry visible combinationally on rdata.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push_ok) wptr_d = wptr_q + PTR_W'(1);
        if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_trace_writer.sv
// Captures ALU samples into a record FIFO and serializes each record as four
// 32-bit words over valid/ready. Samples are staged one cycle before the FIFO.
module alu_trace_writer
    import alu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_valid,
    input  logic [F_W-1:0]    cap_f,
    input  logic [WORD_W-1:0] cap_a,
    input  logic [WORD_W-1:0] cap_b,
    input  logic [WORD_W-1:0] cap_y,
    input  logic              cap_zero,
    input  logic              cap_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  rec_count,
    output logic [CNT_W-1:0]  drop_count
);

    logic              stage_vld_q, stage_vld_d;
    trace_rec_t        stage_rec_q, stage_rec_d;
    trace_state_t      state_q, state_d;
    trace_rec_t        rec_q, rec_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  rec_count_q, rec_count_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;

    logic              fifo_push;
    logic              fifo_pop;
    trace_rec_t        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (stage_rec_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Capture: the staged sample is pushed or dropped against the registered full flag.
    always_comb begin
        stage_vld_d  = cap_valid;
        stage_rec_d  = pack_rec(cap_ovf, cap_zero, cap_f, cap_a, cap_b, cap_y);
        fifo_push    = stage_vld_q && !fifo_full;
        rec_count_d  = rec_count_q + CNT_W'(fifo_push);
        drop_count_d = drop_count_q;
        if (stage_vld_q && fifo_full && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
    end

    // Serializer: outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        state_d    = state_q;
        rec_d      = rec_q;
        fifo_pop   = 1'b0;
        out_data_d = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rec_d    = fifo_rdata;
                    state_d  = W0;
                end
            end
            W0: if (out_ready) state_d = W1;
            W1: if (out_ready) state_d = W2;
            W2: if (out_ready) state_d = W3;
            W3: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        rec_d    = fifo_rdata;
                        state_d  = W0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d != IDLE);
        out_last_d  = (state_d == W3);
        case (state_d)
            W0:      out_data_d = WORD_W'({rec_d[OVF_BIT], rec_d[ZERO_BIT], rec_d[F_LSB +: F_W]});
            W1:      out_data_d = rec_d[A_LSB +: WORD_W];
            W2:      out_data_d = rec_d[B_LSB +: WORD_W];
            W3:      out_data_d = rec_d[Y_LSB +: WORD_W];
            default: out_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_vld_q  <= 1'b0;
            stage_rec_q  <= '0;
            state_q      <= IDLE;
            rec_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            rec_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            stage_rec_q  <= stage_rec_d;
            state_q      <= state_d;
            rec_q        <= rec_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            rec_count_q  <= rec_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign rec_count  = rec_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_alu_trace_writer.sv
// Bench for alu_trace_writer: an occupancy/word-queue model checked every cycle,
// plus directed scenarios pinned with hand-computed words and counts.
module tb_alu_trace_writer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_valid = 1'b0;
    logic [2:0]  cap_f = '0;
    logic [31:0] cap_a = '0, cap_b = '0, cap_y = '0;
    logic        cap_zero = 1'b0, cap_ovf = 1'b0;
    logic        out_valid, out_last, full, empty;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [CNT_W-1:0] rec_count, drop_count;

    alu_trace_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_f(cap_f),
        .cap_a(cap_a), .cap_b(cap_b), .cap_y(cap_y), .cap_zero(cap_zero),
        .cap_ovf(cap_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .full(full), .empty(empty),
        .rec_count(rec_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO occupancy, words left in the record on the link, pending sample, expected words.
    logic [31:0] exp_q[$];
    logic [31:0] seen_w[$];
    logic        seen_l[$];
    int          m_fifo = 0, m_words = 0, m_old_fifo, m_old_words;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_w[4];
    logic [31:0] m_rec = '0, m_drop = '0, m_dummy;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_fifo = 0; m_words = 0; m_pend = 1'b0; m_rec = '0; m_drop = '0;
        end else begin
            if (out_valid && out_ready) begin
                seen_w.push_back(out_data);
                seen_l.push_back(out_last);
            end
            m_old_fifo  = m_fifo;
            m_old_words = m_words;
            if (m_old_words > 0 && out_ready) begin
                if (exp_q.size() > 0) m_dummy = exp_q.pop_front();
                m_words--;
            end
            if (m_old_fifo > 0 && (m_old_words == 0 || (m_old_words == 1 && out_ready))) begin
                m_fifo--;
                m_words = 4;
            end
            if (m_pend) begin
                if (m_old_fifo == int'(DEPTH)) begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                end else begin
                    m_fifo++;
                    m_rec++;
                    for (int k = 0; k < 4; k++) exp_q.push_back(m_pend_w[k]);
                end
            end
            m_pend      = cap_valid;
            m_pend_w[0] = 32'({cap_ovf, cap_zero, cap_f});
            m_pend_w[1] = cap_a;
            m_pend_w[2] = cap_b;
            m_pend_w[3] = cap_y;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cyc_out_valid", 64'(out_valid), 64'(m_words != 0));
            if (m_words != 0 && exp_q.size() > 0) begin
                chk("cyc_out_data", 64'(out_data), 64'(exp_q[0]));
                chk("cyc_out_last", 64'(out_last), 64'(m_words == 1));
            end
            chk("cyc_empty", 64'(empty), 64'(m_fifo == 0));
            chk("cyc_full", 64'(full), 64'(m_fifo == int'(DEPTH)));
            chk("cyc_rec_count", 64'(rec_count), 64'(m_rec));
            chk("cyc_drop_count", 64'(drop_count), 64'(m_drop));
        end
    end

    task automatic set_cap(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] y, input logic z, input logic o);
        cap_valid = 1'b1; cap_f = f; cap_a = a; cap_b = b; cap_y = y; cap_zero = z; cap_ovf = o;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cap_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((m_words != 0 || m_fifo != 0 || m_pend || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_drain_in_time"}, 64'(n < 300), 64'(1));
        chk({name, "_empty_after"}, 64'(empty), 64'(1));
    endtask

    task automatic chk_seen(input string name, input int idx, input logic [31:0] exp);
        logic [31:0] v = 'x;
        if (idx < seen_w.size()) v = seen_w[idx];
        chk(name, 64'(v), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, held, run, n;
        bit found;

        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_data", 64'(out_data), 64'(0));
        chk("reset_empty", 64'(empty), 64'(1));
        chk("reset_full", 64'(full), 64'(0));
        chk("reset_rec_count", 64'(rec_count), 64'(0));
        chk("reset_drop_count", 64'(drop_count), 64'(0));

        // Add record and first-word latency
        base = seen_w.size();
        set_cap(3'd2, 32'h5, 32'h3, 32'h8, 1'b0, 1'b0);
        cap_valid = 1'b0;
        chk("lat_after_t", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_after_t1", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_after_t2", 64'(out_valid), 64'(1));
        chk("lat_word0", 64'(out_data), 64'h2);
        drain("add");
        chk_seen("add_w0", base, 32'h2);
        chk_seen("add_w1", base + 1, 32'h5);
        chk_seen("add_w2", base + 2, 32'h3);
        chk_seen("add_w3", base + 3, 32'h8);
        chk("add_last_w0", 64'(seen_l.size() > base ? seen_l[base] : 1'bx), 64'(0));
        chk("add_last_w3", 64'(seen_l.size() > base + 3 ? seen_l[base + 3] : 1'bx), 64'(1));

        // Overflow flag and zero flag records
        base = seen_w.size();
        set_cap(3'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        set_cap(3'd6, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0);
        cap_valid = 1'b0;
        drain("flags");
        chk_seen("ovf_w0", base, 32'h12);
        chk_seen("ovf_w3", base + 3, 32'h8000_0000);
        chk_seen("zero_w0", base + 4, 32'h0E);
        chk_seen("zero_w3", base + 7, 32'h0);

        // Backpressure held in W1 for 10 cycles
        base = seen_w.size();
        set_cap(3'd3, 32'hA5A5_0003, 32'h5A5A_0003, 32'h0000_0033, 1'b0, 1'b0);
        cap_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_data == 32'hA5A5_0003) held++;
            @(negedge clk);
        end
        chk("bp_hold_cycles", 64'(held), 64'(10));
        out_ready = 1'b1;
        drain("bp");
        chk_seen("bp_w0", base, 32'h3);
        chk_seen("bp_w1", base + 1, 32'hA5A5_0003);
        chk_seen("bp_w2", base + 2, 32'h5A5A_0003);
        chk_seen("bp_w3", base + 3, 32'h0000_0033);
        chk("bp_count", 64'(seen_w.size() - base), 64'(4));

        // Buffer overflow: 18 captures, DEPTH+1 fit
        do_reset();
        out_ready = 1'b0;
        base = seen_w.size();
        for (int i = 0; i < 18; i++) begin
            set_cap(3'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'h3000 + 32'(i), i[0], i[1]);
        end
        cap_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_rec_count", 64'(rec_count), 64'(17));
        chk("ovf_drop_count", 64'(drop_count), 64'(1));
        chk("ovf_full", 64'(full), 64'(1));
        out_ready = 1'b1;
        drain("ovf");
        chk("ovf_words", 64'(seen_w.size() - base), 64'(68));
        chk_seen("ovf_rec1_a", base + 5, 32'h1001);
        chk_seen("ovf_rec15_w0", base + 60, 32'h1F);
        chk_seen("ovf_rec16_y", base + 67, 32'h3010);

        // Back-to-back records stream with no bubble
        for (int i = 0; i < 3; i++) set_cap(3'd1, 32'h40 + 32'(i), 32'h50, 32'h60, 1'b0, 1'b0);
        cap_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        while (out_valid && run < 20) begin
            run++;
            @(negedge clk);
        end
        chk("b2b_valid_run", 64'(run), 64'(12));
        drain("b2b");

        // Reset while in W2 with 5 records queued
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) set_cap(3'd4, 32'hAAAA_0000 + 32'(i), 32'hBEEF_0000 + 32'(i), 32'h7, 1'b0, 1'b0);
        cap_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_queued_count", 64'(rec_count), 64'(m_rec));
        out_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_valid && out_data == 32'hBEEF_0000) found = 1;
            else @(negedge clk);
        end
        chk("rst_reached_w2", 64'(found), 64'(1));
        chk("rst_fifo_depth_5", 64'(m_fifo), 64'(5));
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_rec_count", 64'(rec_count), 64'(0));
        chk("rst_drop_count", 64'(drop_count), 64'(0));
        base = seen_w.size();
        set_cap(3'd1, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
        cap_valid = 1'b0;
        drain("post_rst");
        chk_seen("post_rst_w0", base, 32'h1);
        chk_seen("post_rst_w1", base + 1, 32'h11);
        chk_seen("post_rst_w3", base + 3, 32'h33);
        chk("post_rst_words", 64'(seen_w.size() - base), 64'(4));
        chk("post_rst_rec_count", 64'(rec_count), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
